// File: rtl/memcpy_burst_engine_if.sv
// memcpy_burst_engine_if: command, AXI4 AR/R and output stream bundle
// master = engine side, slave = splitter / AXI fabric / consumer side
interface memcpy_burst_engine_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic              burst_start;
  logic [ADDR_W-1:0] burst_addr;
  logic [7:0]        burst_len;
  logic              burst_on;
  logic              burst_done;
  logic              burst_err;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] dout_data;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    input  burst_start, burst_addr, burst_len,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  dout_ready,
    output burst_on, burst_done, burst_err,
    output m_araddr, m_arlen, m_arvalid, m_rready,
    output dout_data, dout_valid
  );

  modport slave (
    output burst_start, burst_addr, burst_len,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    output dout_ready,
    input  burst_on, burst_done, burst_err,
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    input  dout_data, dout_valid
  );
endinterface

// File: rtl/memcpy_burst_engine.sv
// memcpy_burst_engine: one command -> one AXI4 INCR read -> R beats streamed out
// Bad commands (zero/oversize/4KB-crossing) finish with burst_err and no AR.
module memcpy_burst_engine #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int MAX_LEN = 64
) (
  input logic clk,
  input logic rst,
  memcpy_burst_engine_if.master bus
);
  localparam logic [8:0] PAGE_BEATS = 9'd64;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [8:0] span;
  logic       cmd_bad;
  logic       beat;
  logic       last;
  logic       unused_low;

  assign unused_low = ^bus.burst_addr[5:0];

  assign span    = {3'b0, bus.burst_addr[11:6]} + {1'b0, bus.burst_len};
  assign cmd_bad = (bus.burst_len == 8'd0)
                 || ({1'b0, bus.burst_len} > 9'(MAX_LEN))
                 || (span > PAGE_BEATS);
  assign beat    = (state_q == S_DATA) && bus.m_rvalid && bus.dout_ready;
  assign last    = (cnt_q == arlen_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      arlen_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      arlen_q <= arlen_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state: command check, AR handshake, beat counting, error capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    arlen_d = arlen_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.burst_start) begin
          addr_d  = {bus.burst_addr[ADDR_W-1:6], 6'b0};
          arlen_d = bus.burst_len - 8'd1;
          cnt_d   = '0;
          err_d   = cmd_bad;
          state_d = cmd_bad ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.m_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if ((bus.m_rresp != 2'b00) || (bus.m_rlast != last))
            err_d = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: AR from latched command, R/stream pass-through only in DATA
  always_comb begin
    bus.burst_on   = (state_q == S_ADDR) || (state_q == S_DATA);
    bus.burst_done = (state_q == S_DONE);
    bus.burst_err  = err_q;
    bus.m_araddr   = addr_q;
    bus.m_arlen    = arlen_q;
    bus.m_arvalid  = (state_q == S_ADDR);
    bus.m_rready   = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout_data  = '0;
    if (state_q == S_DATA) begin
      bus.m_rready   = bus.dout_ready;
      bus.dout_valid = bus.m_rvalid;
      bus.dout_data  = bus.m_rdata;
    end
  end
endmodule

// File: tb/tb_memcpy_burst_engine.sv
// tb_memcpy_burst_engine: directed scenarios with a small AXI read responder
// and stream sink; expected values are hand-computed per scenario.
module tb_memcpy_burst_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memcpy_burst_engine_if bus ();

  memcpy_burst_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [63:0] o_araddr;
  logic [7:0]  o_arlen;
  int o_arcnt, o_arvcyc, o_beats, o_data_bad, o_rdy_bad;
  int o_done_cnt, o_done_cyc;
  logic o_err, o_err_k1;

  function automatic logic [511:0] mk_data(input int i);
    logic [511:0] d;
    for (int j = 0; j < 16; j++)
      d[j*32 +: 32] = 32'hA5A5_0000 + 32'(i * 16 + j);
    return d;
  endfunction

  task automatic clear_inputs();
    bus.burst_start = 1'b0;
    bus.burst_addr  = '0;
    bus.burst_len   = '0;
    bus.m_arready   = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rresp     = 2'b00;
    bus.m_rlast     = 1'b0;
    bus.m_rvalid    = 1'b0;
    bus.dout_ready  = 1'b0;
  endtask

  // Runs one command from the start cycle (k=0) until one cycle after done.
  task automatic do_burst(input logic [63:0] addr, input logic [7:0] len,
                          input int ar_delay, input bit toggle,
                          input int bad_beat, input int early_beat,
                          input int extra_start);
    int k;
    int sent;
    bit ar_done;
    bit rv;
    k = 0; sent = 0; ar_done = 0;
    o_araddr = '0; o_arlen = '0;
    o_arcnt = 0; o_arvcyc = 0; o_data_bad = 0; o_rdy_bad = 0;
    o_done_cnt = 0; o_done_cyc = -1; o_err_k1 = 1'bx;
    while (k < 400 && !(o_done_cnt > 0 && k > o_done_cyc + 1)) begin
      @(posedge clk); #1;
      bus.burst_start = (k == 0) || (k == extra_start);
      bus.burst_addr  = addr;
      bus.burst_len   = len;
      bus.dout_ready  = toggle ? k[0] : 1'b1;
      rv = ar_done && (sent < int'(len));
      bus.m_rvalid    = rv;
      bus.m_rdata     = mk_data(sent);
      bus.m_rresp     = (sent == bad_beat) ? 2'b10 : 2'b00;
      bus.m_rlast     = (sent == int'(len) - 1) || (sent == early_beat);
      bus.m_arready   = 1'b0;
      #1;
      if (bus.m_arvalid === 1'b1) begin
        bus.m_arready = (o_arvcyc >= ar_delay);
        o_arvcyc++;
      end
      #1;
      if (bus.m_arvalid === 1'b1 && bus.m_arready) begin
        o_arcnt++;
        o_araddr = bus.m_araddr;
        o_arlen  = bus.m_arlen;
      end
      if (rv) begin
        if (bus.m_rready !== bus.dout_ready) o_rdy_bad++;
        if (bus.dout_valid !== 1'b1) o_data_bad++;
        if (bus.dout_ready) begin
          if (bus.dout_data !== mk_data(sent)) o_data_bad++;
          sent++;
        end
      end else if (bus.dout_valid !== 1'b0 || bus.m_rready !== 1'b0) begin
        o_data_bad++;
      end
      if (bus.burst_done === 1'b1) begin
        o_done_cnt++;
        o_done_cyc = k;
      end
      if (k == 1) o_err_k1 = bus.burst_err;
      if (bus.m_arvalid === 1'b1 && bus.m_arready) ar_done = 1;
      k++;
    end
    o_beats = sent;
    o_err = bus.burst_err;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (bus.burst_on !== 1'b0) begin errors++; $display("FAIL rst_on got %0b want 0", bus.burst_on); end
    checks++; if (bus.burst_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", bus.burst_done); end
    checks++; if (bus.burst_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", bus.burst_err); end
    checks++; if (bus.m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %0b want 0", bus.m_arvalid); end
    checks++; if (bus.m_araddr !== 64'h0) begin errors++; $display("FAIL rst_araddr got %0h want 0", bus.m_araddr); end
    checks++; if (bus.m_arlen !== 8'h0) begin errors++; $display("FAIL rst_arlen got %0h want 0", bus.m_arlen); end
    checks++; if (bus.m_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %0b want 0", bus.m_rready); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dvalid got %0b want 0", bus.dout_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_burst(64'h1000_0040, 8'd4, 0, 1'b0, -1, -1, -1);
    checks++; if (o_araddr !== 64'h1000_0040) begin errors++; $display("FAIL basic_araddr got %0h want 10000040", o_araddr); end
    checks++; if (o_arlen !== 8'd3) begin errors++; $display("FAIL basic_arlen got %0d want 3", o_arlen); end
    checks++; if (o_arcnt !== 1) begin errors++; $display("FAIL basic_arcnt got %0d want 1", o_arcnt); end
    checks++; if (o_beats !== 4) begin errors++; $display("FAIL basic_beats got %0d want 4", o_beats); end
    checks++; if (o_data_bad !== 0) begin errors++; $display("FAIL basic_data got %0d bad want 0", o_data_bad); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", o_done_cnt); end
    checks++; if (o_done_cyc !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", o_done_cyc); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL basic_err got %0b want 0", o_err); end
  endtask

  task automatic test_long_backpressure();
    do_burst(64'h2000_0000, 8'd64, 5, 1'b1, -1, -1, -1);
    checks++; if (o_arvcyc !== 6) begin errors++; $display("FAIL long_arvalid_cyc got %0d want 6", o_arvcyc); end
    checks++; if (o_arlen !== 8'd63) begin errors++; $display("FAIL long_arlen got %0d want 63", o_arlen); end
    checks++; if (o_beats !== 64) begin errors++; $display("FAIL long_beats got %0d want 64", o_beats); end
    checks++; if (o_data_bad !== 0) begin errors++; $display("FAIL long_data got %0d bad want 0", o_data_bad); end
    checks++; if (o_rdy_bad !== 0) begin errors++; $display("FAIL long_rready got %0d bad want 0", o_rdy_bad); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL long_done_cnt got %0d want 1", o_done_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL long_err got %0b want 0", o_err); end
  endtask

  task automatic test_bad_cmd();
    logic [63:0] a [3];
    logic [7:0]  l [3];
    a[0] = 64'h0;    l[0] = 8'd0;
    a[1] = 64'h0;    l[1] = 8'd65;
    a[2] = 64'h0FC0; l[2] = 8'd2;
    for (int i = 0; i < 3; i++) begin
      do_burst(a[i], l[i], 0, 1'b0, -1, -1, -1);
      checks++; if (o_arvcyc !== 0) begin errors++; $display("FAIL bad%0d_arvalid got %0d want 0", i, o_arvcyc); end
      checks++; if (o_done_cyc !== 1) begin errors++; $display("FAIL bad%0d_latency got %0d want 1", i, o_done_cyc); end
      checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL bad%0d_done_cnt got %0d want 1", i, o_done_cnt); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL bad%0d_err got %0b want 1", i, o_err); end
    end
    do_burst(64'h0FC0, 8'd1, 0, 1'b0, -1, -1, -1);
    checks++; if (o_arcnt !== 1) begin errors++; $display("FAIL edge_arcnt got %0d want 1", o_arcnt); end
    checks++; if (o_err_k1 !== 1'b0) begin errors++; $display("FAIL edge_err_clear got %0b want 0", o_err_k1); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL edge_err got %0b want 0", o_err); end
    checks++; if (o_done_cyc !== 3) begin errors++; $display("FAIL edge_latency got %0d want 3", o_done_cyc); end
  endtask

  task automatic test_resp_err();
    do_burst(64'h4000_0000, 8'd3, 0, 1'b0, 1, -1, -1);
    checks++; if (o_beats !== 3) begin errors++; $display("FAIL rresp_beats got %0d want 3", o_beats); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL rresp_done got %0d want 1", o_done_cnt); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rresp_err got %0b want 1", o_err); end
    do_burst(64'h4000_1000, 8'd3, 0, 1'b0, -1, 0, -1);
    checks++; if (o_beats !== 3) begin errors++; $display("FAIL rlast_beats got %0d want 3", o_beats); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rlast_err got %0b want 1", o_err); end
    do_burst(64'h4000_2000, 8'd2, 0, 1'b0, -1, -1, -1);
    checks++; if (o_err_k1 !== 1'b0) begin errors++; $display("FAIL clr_err_k1 got %0b want 0", o_err_k1); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL clr_err got %0b want 0", o_err); end
  endtask

  task automatic test_ignore_start();
    do_burst(64'h5000_0080, 8'd8, 0, 1'b0, -1, -1, 4);
    checks++; if (o_arcnt !== 1) begin errors++; $display("FAIL ign_arcnt got %0d want 1", o_arcnt); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt got %0d want 1", o_done_cnt); end
    checks++; if (o_beats !== 8) begin errors++; $display("FAIL ign_beats got %0d want 8", o_beats); end
    checks++; if (o_done_cyc !== 10) begin errors++; $display("FAIL ign_latency got %0d want 10", o_done_cyc); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ign_err got %0b want 0", o_err); end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    bus.burst_start = 1'b1;
    bus.burst_addr  = 64'h3000_0000;
    bus.burst_len   = 8'd16;
    bus.m_arready   = 1'b1;
    bus.dout_ready  = 1'b1;
    @(posedge clk); #1;
    bus.burst_start = 1'b0;
    @(posedge clk); #1;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = mk_data(0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_dvalid got %0b want 1", bus.dout_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.burst_on !== 1'b0) begin errors++; $display("FAIL mid_on got %0b want 0", bus.burst_on); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_dvalid got %0b want 0", bus.dout_valid); end
    checks++; if (bus.m_rready !== 1'b0) begin errors++; $display("FAIL mid_rready got %0b want 0", bus.m_rready); end
    checks++; if (bus.m_araddr !== 64'h0) begin errors++; $display("FAIL mid_araddr got %0h want 0", bus.m_araddr); end
    checks++; if (bus.burst_done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", bus.burst_done); end
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    do_burst(64'h3000_0100, 8'd2, 0, 1'b0, -1, -1, -1);
    checks++; if (o_beats !== 2) begin errors++; $display("FAIL post_beats got %0d want 2", o_beats); end
    checks++; if (o_done_cyc !== 4) begin errors++; $display("FAIL post_latency got %0d want 4", o_done_cyc); end
    checks++; if (o_araddr !== 64'h3000_0100) begin errors++; $display("FAIL post_araddr got %0h want 30000100", o_araddr); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL post_err got %0b want 0", o_err); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_long_backpressure();
    test_bad_cmd();
    test_resp_err();
    test_ignore_start();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
